// File: rtl/alarm_sequencer.sv
// Alarm sequencer: detects the alarm minute and runs the ring / snooze / stop cycle.
// Latency 1 clk from input edge or tick to AA/state; no backpressure, inputs are levels and pulses.
module alarm_sequencer #(
    parameter int SNOOZE_SEC       = 300,
    parameter int RING_TIMEOUT_SEC = 60,
    parameter int MAX_SNOOZES      = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_1hz_i,
    input  logic [4:0] cur_hr_i,
    input  logic [5:0] cur_min_i,
    input  logic [4:0] alm_hr_i,
    input  logic [5:0] alm_min_i,
    input  logic       alarm_on_i,
    input  logic       mute_i,
    input  logic       snooze_i,
    input  logic       stop_i,
    output logic       aa_o,
    output logic       beep_o,
    output logic       snoozing_o,
    output logic [1:0] snz_left_o,
    output logic       missed_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [9:0] SNZ_LOAD = 10'(SNOOZE_SEC);
    localparam logic [9:0] RING_LIM = 10'(RING_TIMEOUT_SEC);
    localparam logic [1:0] SNZ_MAX  = 2'(MAX_SNOOZES);

    state_t     state_q, state_d;
    logic [9:0] ring_cnt_q, ring_cnt_d;
    logic [9:0] snz_tmr_q, snz_tmr_d;
    logic [1:0] snz_cnt_q, snz_cnt_d;
    logic       beep_q, beep_d;
    logic       missed_q, missed_d;
    logic       match_q, snooze_q, stop_q;

    logic match, match_rise, snz_p, stp_p;

    assign match      = alarm_on_i && (cur_hr_i == alm_hr_i) && (cur_min_i == alm_min_i);
    assign match_rise = match && !match_q;
    assign snz_p      = snooze_i && !snooze_q;
    assign stp_p      = stop_i && !stop_q;

    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_tmr_d  = snz_tmr_q;
        snz_cnt_d  = snz_cnt_q;
        beep_d     = beep_q;
        missed_d   = missed_q;
        if (!alarm_on_i) begin
            state_d    = IDLE;
            ring_cnt_d = '0;
            snz_tmr_d  = '0;
            snz_cnt_d  = '0;
            beep_d     = 1'b0;
            missed_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Edge-only trigger: a muted edge is consumed for the whole minute.
                    if (match_rise && !mute_i) begin
                        state_d    = RING;
                        ring_cnt_d = '0;
                        beep_d     = 1'b1;
                        missed_d   = 1'b0;
                    end
                end
                RING: begin
                    if (stp_p) begin
                        state_d = DONE;
                    end else if (snz_p && (snz_cnt_q < SNZ_MAX)) begin
                        state_d   = SNOOZE;
                        snz_cnt_d = snz_cnt_q + 2'd1;
                        snz_tmr_d = SNZ_LOAD;
                    end else if (tick_1hz_i) begin
                        beep_d     = !beep_q;
                        ring_cnt_d = ring_cnt_q + 10'd1;
                        if (ring_cnt_q + 10'd1 == RING_LIM) begin
                            state_d  = DONE;
                            missed_d = 1'b1;
                        end
                    end
                end
                SNOOZE: begin
                    if (stp_p) begin
                        state_d = DONE;
                    end else if (tick_1hz_i) begin
                        snz_tmr_d = snz_tmr_q - 10'd1;
                        if (snz_tmr_q == 10'd1) begin
                            state_d    = RING;
                            ring_cnt_d = '0;
                            beep_d     = 1'b1;
                        end
                    end
                end
                default: begin
                    // Hold until the alarm minute passes so the same minute cannot retrigger.
                    if (!match) begin
                        state_d   = IDLE;
                        snz_cnt_d = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            ring_cnt_q <= '0;
            snz_tmr_q  <= '0;
            snz_cnt_q  <= '0;
            beep_q     <= 1'b0;
            missed_q   <= 1'b0;
            match_q    <= 1'b0;
            snooze_q   <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            snz_tmr_q  <= snz_tmr_d;
            snz_cnt_q  <= snz_cnt_d;
            beep_q     <= beep_d;
            missed_q   <= missed_d;
            match_q    <= match;
            snooze_q   <= snooze_i;
            stop_q     <= stop_i;
        end
    end

    assign aa_o       = (state_q == RING);
    assign beep_o     = aa_o && beep_q;
    assign snoozing_o = (state_q == SNOOZE);
    assign snz_left_o = SNZ_MAX - snz_cnt_q;
    assign missed_o   = missed_q;
    assign state_o    = state_q;

endmodule
